digilent_pmod_da2_spi_transmitter: RTL and testbench

SPI master that serialises 16-bit samples to a Digilent PmodDA2 (two DAC121S101 12-bit DACs). It is the output-side counterpart of the microphone SPI capture path: upstream logic such as a tone or waveform generator hands it a word over a valid/ready handshake, and it generates SYNC (cs_n), SCLK and DIN with a fixed frame format. One frame is sent per accepted word, MSB first.

---
 rtl/digilent_pmod_da2_spi_transmitter.sv | 131 +++++++++++++
 tb/tb_digilent_pmod_da2_spi_transmitter.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/digilent_pmod_da2_spi_transmitter.sv
// SPI master for the Digilent PmodDA2: one 16-bit word per valid/ready handshake, sent MSB first on SYNC/SCLK/DIN.
// Optional `define PMOD_DA2_DUAL_CHANNEL_EN adds in_data_b/sdi_b so both DACs are loaded in the same frame.
module digilent_pmod_da2_spi_transmitter #(
    parameter int CLK_DIV    = 2,  // system clocks per SCLK half-period, >= 1
    parameter int GAP_CYCLES = 4   // cs_n high time between frames, >= 1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        in_valid,
    input  logic [15:0] in_data,
`ifdef PMOD_DA2_DUAL_CHANNEL_EN
    input  logic [15:0] in_data_b,
    output logic        sdi_b,
`endif
    output logic        in_ready,
    output logic        cs_n,
    output logic        sck,
    output logic        sdi,
    output logic        busy
);

    localparam int HC_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int GC_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [HC_W-1:0] HC_LAST = HC_W'(CLK_DIV - 1);
    localparam logic [GC_W-1:0] GC_LAST = GC_W'(GAP_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        GAP
    } state_t;

    state_t          r_state;
    logic [15:0]     r_shift;
    logic [3:0]      r_bit_cnt;
    logic [HC_W-1:0] r_half_cnt;
    logic            r_low_half;
    logic [GC_W-1:0] r_gap_cnt;
    logic            r_cs_n;
    logic            r_sck;
`ifdef PMOD_DA2_DUAL_CHANNEL_EN
    logic [15:0]     r_shift_b;
`endif

    logic w_accept;

    // NOTE: in_ready is gated by reset so no word can be taken while reset is held.
    assign in_ready = (r_state == IDLE) && !reset;
    assign busy     = (r_state != IDLE) && !reset;
    assign w_accept = in_valid && in_ready;

    // The shift register is flushed to zero outside SHIFT, so its MSB is the glitch-free DIN pin.
    assign cs_n = r_cs_n;
    assign sck  = r_sck;
    assign sdi  = r_shift[15];
`ifdef PMOD_DA2_DUAL_CHANNEL_EN
    assign sdi_b = r_shift_b[15];
`endif

    // NOTE: all state is updated with non-blocking assignments so every branch sees pre-edge values.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state    <= IDLE;
            r_shift    <= '0;
            r_bit_cnt  <= '0;
            r_half_cnt <= '0;
            r_low_half <= 1'b0;
            r_gap_cnt  <= '0;
            r_cs_n     <= 1'b1;
            r_sck      <= 1'b1;
`ifdef PMOD_DA2_DUAL_CHANNEL_EN
            r_shift_b  <= '0;
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_state    <= SHIFT;
                        r_shift    <= in_data;
                        r_bit_cnt  <= 4'd15;
                        r_half_cnt <= '0;
                        r_low_half <= 1'b0;
                        r_cs_n     <= 1'b0;
                        r_sck      <= 1'b1;
`ifdef PMOD_DA2_DUAL_CHANNEL_EN
                        r_shift_b  <= in_data_b;
`endif
                    end
                end

                SHIFT: begin
                    if (r_half_cnt != HC_LAST) begin
                        r_half_cnt <= r_half_cnt + 1'b1;
                    end else if (!r_low_half) begin
                        // Mid-bit: falling SCLK, where the DAC samples DIN.
                        r_half_cnt <= '0;
                        r_low_half <= 1'b1;
                        r_sck      <= 1'b0;
                    end else begin
                        // End of bit: the extra shift after bit 0 leaves the register all-zero for GAP.
                        r_shift    <= {r_shift[14:0], 1'b0};
`ifdef PMOD_DA2_DUAL_CHANNEL_EN
                        r_shift_b  <= {r_shift_b[14:0], 1'b0};
`endif
                        r_sck      <= 1'b1;
                        r_half_cnt <= '0;
                        r_low_half <= 1'b0;
                        if (r_bit_cnt == 4'd0) begin
                            r_state   <= GAP;
                            r_gap_cnt <= '0;
                            r_cs_n    <= 1'b1;
                        end else begin
                            r_bit_cnt <= r_bit_cnt - 4'd1;
                        end
                    end
                end

                GAP: begin
                    if (r_gap_cnt == GC_LAST) begin
                        r_state <= IDLE;
                    end else begin
                        r_gap_cnt <= r_gap_cnt + 1'b1;
                    end
                end

                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_digilent_pmod_da2_spi_transmitter.sv
// Bench for digilent_pmod_da2_spi_transmitter: a pin-level monitor decodes frames and a timing model checks them.
// Two instances: defaults (CLK_DIV=2, GAP_CYCLES=4) and the fast corner (1, 1); `sel` picks the one under test.
module tb_digilent_pmod_da2_spi_transmitter;

    typedef struct {
        int          start;
        int          first_fall;
        int          falls;
        int          low_len;
        logic [15:0] word;
        logic [15:0] word_b;
    } frame_t;

    typedef struct {
        int          cyc;
        logic [15:0] data;
        logic [15:0] data_b;
    } acc_t;

    logic        clock = 1'b0;
    logic        reset;
    logic        v;
    logic        sel;
    logic [15:0] d;
    logic [15:0] d_b;

    logic valid0, valid1;
    logic ready0, cs0, sck0, sdi0, busy0;
    logic ready1, cs1, sck1, sdi1, busy1;
    logic sdib0, sdib1;

    int n_vec = 0;
    int n_err = 0;

    always #5 clock = ~clock;

    assign valid0 = v && !sel;
    assign valid1 = v && sel;

    digilent_pmod_da2_spi_transmitter #(.CLK_DIV(2), .GAP_CYCLES(4)) u_dut0 (
        .clock    (clock),
        .reset    (reset),
        .in_valid (valid0),
        .in_data  (d),
`ifdef PMOD_DA2_DUAL_CHANNEL_EN
        .in_data_b(d_b),
        .sdi_b    (sdib0),
`endif
        .in_ready (ready0),
        .cs_n     (cs0),
        .sck      (sck0),
        .sdi      (sdi0),
        .busy     (busy0)
    );

    digilent_pmod_da2_spi_transmitter #(.CLK_DIV(1), .GAP_CYCLES(1)) u_dut1 (
        .clock    (clock),
        .reset    (reset),
        .in_valid (valid1),
        .in_data  (d),
`ifdef PMOD_DA2_DUAL_CHANNEL_EN
        .in_data_b(d_b),
        .sdi_b    (sdib1),
`endif
        .in_ready (ready1),
        .cs_n     (cs1),
        .sck      (sck1),
        .sdi      (sdi1),
        .busy     (busy1)
    );

`ifndef PMOD_DA2_DUAL_CHANNEL_EN
    assign sdib0 = 1'b0;
    assign sdib1 = 1'b0;
`endif

    logic m_ready, m_cs_n, m_sck, m_sdi, m_sdi_b, m_busy;
    assign m_ready = sel ? ready1 : ready0;
    assign m_cs_n  = sel ? cs1    : cs0;
    assign m_sck   = sel ? sck1   : sck0;
    assign m_sdi   = sel ? sdi1   : sdi0;
    assign m_sdi_b = sel ? sdib1  : sdib0;
    assign m_busy  = sel ? busy1  : busy0;

    // Pin monitor: samples on the falling clock edge, away from the active edge.
    int     cyc = 0;
    acc_t   acc_q[$];
    frame_t frm_q[$];
    int     rdy_q[$];
    frame_t cur;
    int     sdi_bad = 0;
    int     idle_tog = 0;
    int     bad_fall = 0;
    logic   p_ready = 1'b0, p_cs_n = 1'b1, p_sck = 1'b1, p_sdi = 1'b0, p_sdi_b = 1'b0;

    always @(negedge clock) begin
        cyc++;
        if (v && m_ready) acc_q.push_back('{cyc: cyc, data: d, data_b: d_b});
        if (m_ready && !p_ready) rdy_q.push_back(cyc);
        if (!m_cs_n && p_cs_n) begin
            cur = '{default: 0};
            cur.start = cyc;
        end
        if (!m_cs_n) cur.low_len++;
        if (p_sck && !m_sck) begin
            if (m_cs_n) bad_fall++;
            if (cur.falls == 0) cur.first_fall = cyc;
            cur.falls++;
            cur.word   = {cur.word[14:0], m_sdi};
            cur.word_b = {cur.word_b[14:0], m_sdi_b};
        end
        if (m_cs_n && !p_cs_n) frm_q.push_back(cur);
        if (m_cs_n && p_cs_n && (m_sck !== p_sck)) idle_tog++;
        if ((m_sdi !== p_sdi) && !(m_sck && !p_sck) && (m_cs_n === p_cs_n)) sdi_bad++;
        if ((m_sdi_b !== p_sdi_b) && !(m_sck && !p_sck) && (m_cs_n === p_cs_n)) sdi_bad++;
        p_ready = m_ready;
        p_cs_n  = m_cs_n;
        p_sck   = m_sck;
        p_sdi   = m_sdi;
        p_sdi_b = m_sdi_b;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic clear();
        acc_q.delete();
        frm_q.delete();
        rdy_q.delete();
        sdi_bad  = 0;
        idle_tog = 0;
        bad_fall = 0;
    endtask

    task automatic wait_acc(input int n);
        int k = 0;
        while (acc_q.size() < n && k < 400) begin
            tick();
            k++;
        end
        if (acc_q.size() < n) check("accept_timeout", acc_q.size(), n);
    endtask

    task automatic wait_rdy(input int n);
        int k = 0;
        while (rdy_q.size() < n && k < 400) begin
            tick();
            k++;
        end
        if (rdy_q.size() < n) check("ready_timeout", rdy_q.size(), n);
    endtask

    // Reference: frame i carries word a (and b), with every edge placed relative to its accept cycle.
    task automatic verify(input string tag, input int i, input logic [15:0] a, input logic [15:0] b);
        int     dv = sel ? 1 : 2;
        int     gv = sel ? 1 : 4;
        acc_t   ac = '{default: 0};
        frame_t fr = '{default: 0};
        int     rc = -100000;
        ac.cyc = -100000;
        if (acc_q.size() > i) ac = acc_q[i];
        if (frm_q.size() > i) fr = frm_q[i];
        if (rdy_q.size() > i) rc = rdy_q[i];
        check($sformatf("%s.accepted_data", tag), ac.data, a);
        check($sformatf("%s.decoded_word", tag), fr.word, a);
`ifdef PMOD_DA2_DUAL_CHANNEL_EN
        check($sformatf("%s.decoded_word_b", tag), fr.word_b, b);
`else
        if (b == 16'hFFFF) check($sformatf("%s.no_channel_b", tag), fr.word_b, 16'h0000);
`endif
        check($sformatf("%s.sck_falls", tag), fr.falls, 16);
        check($sformatf("%s.cs_low_cycles", tag), fr.low_len, 32 * dv);
        check($sformatf("%s.cs_fall_delay", tag), fr.start - ac.cyc, 1);
        check($sformatf("%s.first_fall_delay", tag), fr.first_fall - ac.cyc, 1 + dv);
        check($sformatf("%s.ready_return", tag), rc - ac.cyc, 32 * dv + 1 + gv);
    endtask

    task automatic check_pins(input string tag);
        check($sformatf("%s.sdi_change_off_edge", tag), sdi_bad, 0);
        check($sformatf("%s.sck_fall_cs_high", tag), bad_fall, 0);
        check($sformatf("%s.sck_toggle_idle", tag), idle_tog, 0);
    endtask

    task automatic send(input string tag, input logic [15:0] a, input logic [15:0] b);
        clear();
        d   = a;
        d_b = b;
        v   = 1'b1;
        wait_acc(1);
        v = 1'b0;
        wait_rdy(1);
        verify(tag, 0, a, b);
        check_pins(tag);
    endtask

    initial begin
        logic [15:0] w1, w2;
        reset = 1'b1;
        v     = 1'b0;
        sel   = 1'b0;
        d     = '0;
        d_b   = '0;

        // Reset state, then 20 idle cycles.
        repeat (3) tick();
        check("reset_pins_dut0", {ready0, cs0, sck0, sdi0, busy0}, 5'b01100);
        check("reset_pins_dut1", {ready1, cs1, sck1, sdi1, busy1}, 5'b01100);
        check("reset_sdi_b", {sdib0, sdib1}, 2'b00);
        reset = 1'b0;
        clear();
        repeat (20) begin
            tick();
            check("idle_pins", {ready0, cs0, sck0, sdi0, busy0}, 5'b11100);
        end
        check("idle_no_toggle", idle_tog, 0);

        // Single word at defaults.
        send("single_0a5c", 16'h0A5C, 16'hFFFF);

        // in_valid held high on the fast instance: back-to-back frames, in_data changes ignored while busy.
        sel = 1'b1;
        tick();
        clear();
        d = 16'h0FFF;
        v = 1'b1;
        wait_acc(1);
        d = 16'($urandom);
        repeat (20) tick();
        d = 16'h0000;
        wait_acc(2);
        v = 1'b0;
        wait_rdy(2);
        verify("b2b0", 0, 16'h0FFF, 16'hFFFF);
        verify("b2b1", 1, 16'h0000, 16'hFFFF);
        check("b2b_accept_spacing", (acc_q.size() > 1) ? acc_q[1].cyc - acc_q[0].cyc : -1, 34);
        check_pins("b2b");

        // Randomized words on randomly chosen instance.
        for (int i = 0; i < 6; i++) begin
            sel = 1'($urandom_range(0, 1));
            tick();
            repeat ($urandom_range(0, 3)) tick();
            send($sformatf("rand%0d", i), 16'($urandom), 16'($urandom));
        end

        // Reset during the 7th bit of 0x0123 aborts the frame cleanly.
        sel = 1'b0;
        tick();
        clear();
        d = 16'h0123;
        v = 1'b1;
        wait_acc(1);
        v = 1'b0;
        repeat (25) tick();
        check("pre_abort_busy", busy0, 1'b1);
        reset = 1'b1;
        tick();
        check("abort_pins", {ready0, cs0, sck0, sdi0, busy0}, 5'b01100);
        reset = 1'b0;
        clear();
        repeat (10) tick();
        check("abort_no_toggle", idle_tog, 0);
        check("abort_idle_pins", {ready0, cs0, sck0, sdi0, busy0}, 5'b11100);
        send("after_abort_0456", 16'h0456, 16'h0ABC);

        // in_valid pulses in SHIFT and GAP are ignored; a pulse on the first IDLE cycle is taken.
        w1 = 16'($urandom);
        w2 = 16'($urandom);
        clear();
        d   = w1;
        d_b = ~w1;
        v   = 1'b1;
        wait_acc(1);
        v = 1'b0;
        repeat (9) tick();
        v = 1'b1;
        d = 16'($urandom);
        tick();
        v = 1'b0;
        repeat (55) tick();
        v   = 1'b1;
        d   = 16'($urandom);
        d_b = 16'($urandom);
        tick();
        v   = 1'b0;
        d   = w2;
        d_b = ~w2;
        repeat (2) tick();
        v = 1'b1;
        wait_acc(2);
        v = 1'b0;
        wait_rdy(2);
        check("pulse_accept_count", acc_q.size(), 2);
        check("pulse_first_idle_accept", (acc_q.size() > 1) ? acc_q[1].cyc - acc_q[0].cyc : -1, 69);
        verify("pulse0", 0, w1, ~w1);
        verify("pulse1", 1, w2, ~w2);
        check_pins("pulse");

`ifdef PMOD_DA2_DUAL_CHANNEL_EN
        send("dual_0111_0eee", 16'h0111, 16'h0EEE);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
